imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream and writes it word-by-word into a writable instruction RAM.
- Uses the same word-index addressing as the fetch path: Address[9:2] selects the word.
- Holds the CPU pipeline stalled while a load is in progress.
- Sits between the boot byte source (UART receiver or testbench) and the instruction RAM's write port.

Parameters:
- ADDR_WIDTH, 8, word-index width; RAM depth = 2^ADDR_WIDTH words (256 by default).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins a load
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction RAM write strobe, one cycle per word
- wr_addr  output  32  byte address of the word written = {zeros, word_idx, 2'b00}
- wr_data  output  32  instruction word
- cpu_hold  output  1  stalls the pipeline while loading
- done  output  1  sticky; load completed successfully
- error  output  1  sticky; header word count exceeds depth

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; byte_ready, wr_en, cpu_hold, done and error = 0; wr_addr and wr_data = 0; internal count and index = 0.
- All outputs are registered.
- A byte transfers on a rising edge when byte_valid & byte_ready.
- Stream format:
  - 2-byte header N (word count), big-endian, high byte first.
  - Then N words of 4 bytes each, big-endian: first byte goes to wr_data[31:24].
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Go to HDR_HI.
  - Clear done, error, word_idx and byte counter.
  - Set cpu_hold=1.
  - byte_ready=1 from the next cycle.
- start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- HDR_HI: accept byte -> N[15:8]; go to HDR_LO.
- HDR_LO: accept byte -> N[7:0], then branch:
  - N==0 -> DONE (no writes).
  - N > 2^ADDR_WIDTH -> ERR.
  - Otherwise -> DATA.
- DATA: accept bytes into a shift register; byte counter runs 0..3. When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - wr_en=1, wr_data=assembled word, wr_addr={word_idx,2'b00}.
  - byte_ready=0.
  - If word_idx+1==N -> DONE; else word_idx++ and return to DATA.
- Latency: 4th byte of a word accepted at edge t -> wr_en high during the cycle after t, for one cycle.
- Throughput: maximum 1 word per 5 cycles.
- DONE: done=1, cpu_hold=0, byte_ready=0.
- ERR: error=1, cpu_hold stays 1, byte_ready=0. Leave only via start or reset.
- byte_ready is 0 in IDLE, WRITE, DONE and ERR. Bytes presented then are not consumed; the source must hold them.
- byte_valid deasserted mid-word: the partial word is retained and the FSM waits indefinitely; there is no timeout.
- N == 2^ADDR_WIDTH is legal. The last wr_addr is {all-ones idx, 2'b00}; word_idx does not wrap before DONE.
- wr_addr bits above ADDR_WIDTH+1 are always 0.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. A partial word is discarded; words already written are not undone.

Test Plan:
- Basic load: start, stream 00 02 08 00 00 03 20 04 00 03 -> two wr_en pulses: (wr_addr 0x0, wr_data 0x08000003) then (0x4, 0x20040003); done=1; cpu_hold falls the cycle done rises.
- Zero length: stream 00 00 -> DONE with no wr_en pulses; done=1, error=0.
- Oversize: header 01 01 (257) with ADDR_WIDTH=8 -> error=1, cpu_hold=1, byte_ready=0; a later start clears error.
- Full depth: N=256 with word k = k -> 256 writes, last at wr_addr 0x3FC with data 0x000000FF; done=1.
- Backpressure and gaps:
  - byte_valid toggled randomly, and bytes presented during WRITE -> no byte lost or duplicated; data matches.
  - byte_ready=0 during each WRITE cycle.
- Reset mid-word: assert reset after 2 data bytes of word 1 -> outputs 0 asynchronously. A following start and a fresh stream 00 01 12 34 56 78 -> single write (0x0, 0x12345678).

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it word-by-word
// into the instruction RAM. The stream is a 2-byte big-endian word count N
// followed by N big-endian 32-bit words. The CPU is held while a load runs.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  // RAM depth in words; 17 bits so that a full 16-bit count can be compared.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_t                  state_reg, state_next;
  logic [15:0]             n_reg, n_next;
  logic [ADDR_WIDTH-1:0]   word_idx_reg, word_idx_next;
  logic [1:0]              byte_cnt_reg, byte_cnt_next;
  logic [23:0]             shift_reg, shift_next;
  logic                    byte_ready_reg, byte_ready_next;
  logic                    wr_en_reg, wr_en_next;
  logic [31:0]             wr_addr_reg, wr_addr_next;
  logic [31:0]             wr_data_reg, wr_data_next;
  logic                    cpu_hold_reg, cpu_hold_next;
  logic                    done_reg, done_next;
  logic                    error_reg, error_next;

  logic                    accept;
  logic [15:0]             n_full;
  logic                    last_word;

  // A byte moves only when the source offers it and the registered ready is high.
  assign accept    = byte_valid & byte_ready_reg;
  // Header count as it becomes complete on the low-byte transfer.
  assign n_full    = {n_reg[15:8], byte_in};
  // Current word is the final one of the program.
  assign last_word = ({{(17-ADDR_WIDTH){1'b0}}, word_idx_reg} + 17'd1) == {1'b0, n_reg};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg          <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      shift_reg      <= '0;
      byte_ready_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      cpu_hold_reg   <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      n_reg          <= n_next;
      word_idx_reg   <= word_idx_next;
      byte_cnt_reg   <= byte_cnt_next;
      shift_reg      <= shift_next;
      byte_ready_reg <= byte_ready_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      cpu_hold_reg   <= cpu_hold_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  // Next-state logic; output registers are derived from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    word_idx_next = word_idx_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = HDR_HI;
          word_idx_next = '0;
          byte_cnt_next = '0;
        end
      end
      HDR_HI: begin
        if (accept) begin
          n_next[15:8] = byte_in;
          state_next   = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          n_next[7:0] = byte_in;
          if (n_full == 16'd0) begin
            state_next = DONE;
          end else if ({1'b0, n_full} > DEPTH) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          shift_next    = {shift_reg[15:0], byte_in};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            state_next   = WRITE;
            wr_data_next = {shift_reg, byte_in};
            wr_addr_next = {{(30-ADDR_WIDTH){1'b0}}, word_idx_reg, 2'b00};
          end
        end
      end
      WRITE: begin
        // The index is left alone on the last word so it never wraps.
        if (last_word) begin
          state_next = DONE;
        end else begin
          word_idx_next = word_idx_reg + 1'b1;
          state_next    = DATA;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    byte_ready_next = (state_next == HDR_HI) || (state_next == HDR_LO) || (state_next == DATA);
    wr_en_next      = (state_next == WRITE);
    cpu_hold_next   = (state_next == HDR_HI) || (state_next == HDR_LO) || (state_next == DATA) ||
                      (state_next == WRITE) || (state_next == ERR);
    done_next       = (state_next == DONE);
    error_next      = (state_next == ERR);
  end

  assign byte_ready = byte_ready_reg;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign cpu_hold   = cpu_hold_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random-gap byte streams against a stream-level model of the
// expected RAM writes and final status flags.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stream[$];
  logic        prev_hold = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] ea, ed;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the next expected (addr, data).
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        check("ready_in_write", 32'(byte_ready), 32'd0);
        check("hold_in_write", 32'(cpu_hold), 32'd1);
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(wr_en), 32'd0);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr", wr_addr, ea);
          check("wr_data", wr_data, ed);
          $display("[TB] write addr=0x%08h data=0x%08h", wr_addr, wr_data);
        end
      end
      if (done && !prev_done) begin
        check("hold_low_at_done", 32'(cpu_hold), 32'd0);
        check("hold_high_before_done", 32'(prev_hold), 32'd1);
      end
    end
    prev_done = done;
    prev_hold = cpu_hold;
  end

  // Pulse start for one cycle; loader must be ready with flags cleared.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", 32'(byte_ready), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("error_cleared", 32'(error), 32'd0);
  endtask

  // Present stream bytes with random gaps; a byte advances only when taken.
  task automatic drive(input int gap_pct);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < stream.size() && cyc < 20000) begin
      if ($urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = stream[i];
      end
      acc = byte_valid && byte_ready;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    byte_valid = 1'b0;
    check("drive_budget", 32'(i), 32'(stream.size()));
  endtask

  // Full load: model expected writes from the stream, run it, check status.
  task automatic do_load(input string name, input int gap_pct);
    int n;
    bit exp_err;
    int cyc;
    n       = {stream[0], stream[1]};
    exp_err = (n > DEPTH);
    exp_addr_q.delete();
    exp_data_q.delete();
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        exp_addr_q.push_back(32'(4 * k));
        exp_data_q.push_back({stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
      end
    end
    pulse_start();
    drive(gap_pct);
    cyc = 0;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, 32'(done), 32'(!exp_err));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({name, "_ready"}, 32'(byte_ready), 32'd0);
    check({name, "_missing_writes"}, 32'(exp_addr_q.size()), 32'd0);
    $display("[TB] load %s N=%0d done=%0b error=%0b", name, n, done, error);
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic two-word load.
    stream = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h04, 8'h00, 8'h03};
    do_load("basic", 0);

    // Zero length.
    stream = '{8'h00, 8'h00};
    do_load("zero", 0);

    // Oversize header, then a fresh start must clear error.
    stream = '{8'h01, 8'h01};
    do_load("oversize", 20);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load("after_err", 30);

    // Full depth, word k = k.
    stream = '{8'h01, 8'h00};
    for (int k = 0; k < DEPTH; k++) push_word(32'(k));
    do_load("full", 20);

    // Random programs with heavy backpressure.
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 12);
      stream = '{};
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int k = 0; k < n; k++) push_word($urandom);
      do_load("random", 45);
    end

    // Reset mid-word: header N=2 plus two data bytes, then async reset.
    exp_addr_q.delete();
    exp_data_q.delete();
    stream = '{8'h00, 8'h02, 8'hAA, 8'hBB};
    pulse_start();
    drive(30);
    #2 reset = 1'b0;
    #1;
    check("arst_ready", 32'(byte_ready), 32'd0);
    check("arst_hold", 32'(cpu_hold), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    do_load("after_reset", 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
